m68k_bus_slave: RTL and testbench
=================================

// Module: m68k_bus_slave
// PURPOSE
//  Target side of the 68010 asynchronous bus: consumes AS/UDS/LDS/RW/FC/A cycles from the CPU
//  (real part or cosim master) and converts each into a single synchronous memory request.
//  Returns read data, drives DTACK, and releases on AS negation.
//  Sits directly downstream of the CPU bus pins, upstream of the RAM/decode fabric, all on C100.
// PARAMETERS
//  SYNC_STAGES  2    flops per synchronizer on AS_n/UDS_n/LDS_n (min 2)
//  WAIT_STATES  0    extra C100 cycles between mem_ack and DTACK assertion (0..15)
//  BERR_CYCLES  256  C100 cycles from REQ entry to bus error (used only with BERR_TIMEOUT_EN)
// PORTS
//  C100        in   1   system clock; all state on rising edge
//  reset       in   1   asynchronous, active-high
//  P_AS_n      in   1   address strobe, async to C100
//  P_RW_n      in   1   1 = read, 0 = write
//  P_UDS_n     in   1   upper data strobe (D15:8)
//  P_LDS_n     in   1   lower data strobe (D7:0)
//  P_FC        in   3   function code
//  P_A         in   23  address A23:A1
//  P_D_in      in   16  data bus input
//  P_D_out     out  16  read data to bus
//  P_D_oe      out  1   drive enable for P_D_out
//  P_DTACK_n   out  1   data transfer acknowledge
//  P_BERR_n    out  1   bus error (constant 1 without BERR_TIMEOUT_EN)
//  mem_req     out  1   memory request, level
//  mem_we      out  1   1 = write
//  mem_addr    out  23  word address (A23:A1)
//  mem_fc      out  3   latched function code
//  mem_be      out  2   byte enables {upper,lower}, active-high
//  mem_wdata   out  16  write data
//  mem_rdata   in   16  read data, valid with mem_ack
//  mem_ack     in   1   one-cycle completion pulse
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; P_DTACK_n=1, P_BERR_n=1, P_D_oe=0, P_D_out=0,
//   mem_req=0, mem_we=0, mem_addr=0, mem_fc=0, mem_be=0, mem_wdata=0; synchronizers preset to 1.
//  as_s/uds_s/lds_s = synchronized inverted strobes (SYNC_STAGES latency).
//  FSM states: IDLE, SETUP, REQ, WAIT, ACK, BERR, DRAIN.
//  IDLE  -> SETUP when as_s && (uds_s || lds_s).
//  SETUP (1 cycle): latch P_A, P_FC, ~P_RW_n, {uds_s,lds_s}, P_D_in -> mem_*; -> REQ.
//  REQ: mem_req=1, held until mem_ack sampled high; mem_req drops on the following edge.
//   On ack: a read captures mem_rdata into P_D_out; -> WAIT, or -> ACK if WAIT_STATES==0.
//   An ack in the same cycle as mem_req's first assertion is legal.
//  WAIT: count WAIT_STATES cycles, then -> ACK.
//  ACK: P_DTACK_n=0; P_D_oe=1 for reads only; hold until !as_s, then -> IDLE.
//   DTACK and P_D_oe negate on the same edge that IDLE is entered.
//  AS-to-DTACK latency (cycles) = SYNC_STAGES + 1 + (cycles to ack) + 1 + WAIT_STATES.
//  Abort (!as_s while in REQ/WAIT): the memory transaction still completes (no req withdrawal);
//   -> DRAIN until ack, then IDLE; DTACK is never asserted for that cycle.
//  Back-to-back: a new cycle is accepted only from IDLE, so AS must be seen negated >=1 cycle.
//  Byte cycle (UDS only or LDS only): mem_be = 2'b10 / 2'b01; P_D_out is driven with all 16 bits.
//  Strobes with AS high are ignored. Writes ignore mem_rdata.
// CONFIGURATION
//  BERR_TIMEOUT_EN defined:
//   - A 16-bit counter clears on REQ entry and increments in REQ.
//   - On reaching BERR_CYCLES: mem_req=0 -> BERR; P_BERR_n=0 until !as_s, then IDLE.
//   - A late mem_ack is ignored.
//   - Abort (DRAIN) is also bounded by BERR_CYCLES.
//  BERR_TIMEOUT_EN undefined: no counter; REQ/DRAIN wait indefinitely; P_BERR_n tied 1.
// STRUCTURE
//  Package m68k_bus_pkg:
//   - state encoding localparams (S_IDLE..S_DRAIN)
//   - FC codes (FC_UDATA=1, FC_UPROG=2, FC_SDATA=5, FC_SPROG=6, FC_IACK=7)
//   - ADDR_W=23, DATA_W=16
//  One sub-module, m68k_sync: a SYNC_STAGES-deep reset-to-1 synchronizer, instanced 3x.
//  Address/FC/RW are sampled only in SETUP (stable by then per 68010 timing); no synchronizer.
// TESTING
//  1. Word read A=0x001000, FC=5, memory acks 3 cycles after req with 0xBEEF:
//     -> mem_be=11, mem_we=0; DTACK low 1 cycle after ack; P_D_out=0xBEEF, oe=1;
//     -> both released the cycle after AS is seen high.
//  2. Byte write A=0x000202, UDS only, D=0x5A00:
//     -> mem_we=1, mem_be=10, mem_wdata=0x5A00; a single mem_req; DTACK low; P_D_oe stays 0.
//  3. WAIT_STATES=4, ack immediate: DTACK delayed exactly 4 cycles versus WAIT_STATES=0.
//  4. AS negated while in REQ, ack after 10 cycles:
//     -> no DTACK; FSM in DRAIN, then IDLE after ack; the next cycle proceeds normally.
//  5. BERR_TIMEOUT_EN, BERR_CYCLES=16, no ack:
//     -> P_BERR_n low at 16 cycles after REQ; mem_req=0; a late ack causes no DTACK.
//  6. Reset pulsed while in ACK:
//     -> DTACK=1, oe=0, mem_req=0 immediately (async); a fresh cycle after reset is accepted.

Source files
------------

// File: rtl/m68k_bus_pkg.sv
// Shared types and constants for the 68010 bus slave.
// Holds the FSM state encoding, function-code values and bus widths.
package m68k_bus_pkg;

    localparam int ADDR_W = 23;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_REQ   = 3'd2,
        S_WAIT  = 3'd3,
        S_ACK   = 3'd4,
        S_BERR  = 3'd5,
        S_DRAIN = 3'd6
    } state_t;

    localparam logic [2:0] FC_UDATA = 3'd1;
    localparam logic [2:0] FC_UPROG = 3'd2;
    localparam logic [2:0] FC_SDATA = 3'd5;
    localparam logic [2:0] FC_SPROG = 3'd6;
    localparam logic [2:0] FC_IACK  = 3'd7;

endpackage

// File: rtl/m68k_sync.sv
// Multi-flop synchronizer for an active-low bus strobe.
// Presets to 1 on reset so a strobe reads as negated until the bus is sampled.
module m68k_sync #(
    parameter int STAGES = 2
) (
    input  logic C100,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // shift the asynchronous input one stage per clock
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // synchronizer flops, negated (1) on reset
    always_ff @(posedge C100 or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/m68k_bus_slave.sv
// 68010 asynchronous bus target: turns each AS/UDS/LDS bus cycle into one
// synchronous memory request on C100, returns read data and DTACK.
// Optional feature macro BERR_TIMEOUT_EN: bounds REQ and DRAIN with a bus
// error timeout of BERR_CYCLES clocks; without it P_BERR_n is tied high.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for AS plus at least one data strobe
// SETUP | latch address, FC, direction, byte enables and write data
// REQ   | mem_req high until mem_ack (or timeout)
// WAIT  | WAIT_STATES extra clocks before DTACK
// ACK   | DTACK low (data driven for reads) until AS negates
// BERR  | BERR low until AS negates
// DRAIN | cycle aborted by the CPU, finish the memory access silently
module m68k_bus_slave
    import m68k_bus_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int WAIT_STATES = 0,
    parameter int BERR_CYCLES = 256
) (
    input  logic              C100,
    input  logic              reset,
    input  logic              P_AS_n,
    input  logic              P_RW_n,
    input  logic              P_UDS_n,
    input  logic              P_LDS_n,
    input  logic [2:0]        P_FC,
    input  logic [ADDR_W-1:0] P_A,
    input  logic [DATA_W-1:0] P_D_in,
    output logic [DATA_W-1:0] P_D_out,
    output logic              P_D_oe,
    output logic              P_DTACK_n,
    output logic              P_BERR_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        mem_fc,
    output logic [1:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

    logic as_n_sync, uds_n_sync, lds_n_sync;
    logic as_s, uds_s, lds_s;
    logic timeout;

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [2:0]        mem_fc_q, mem_fc_d;
    logic [1:0]        mem_be_q, mem_be_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] p_d_out_q, p_d_out_d;
    logic              p_d_oe_q, p_d_oe_d;
    logic              p_dtack_n_q, p_dtack_n_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;

    m68k_sync #(.STAGES(SYNC_STAGES)) u_sync_as (
        .C100(C100), .reset(reset), .d(P_AS_n), .q(as_n_sync)
    );
    m68k_sync #(.STAGES(SYNC_STAGES)) u_sync_uds (
        .C100(C100), .reset(reset), .d(P_UDS_n), .q(uds_n_sync)
    );
    m68k_sync #(.STAGES(SYNC_STAGES)) u_sync_lds (
        .C100(C100), .reset(reset), .d(P_LDS_n), .q(lds_n_sync)
    );

    assign as_s  = ~as_n_sync;
    assign uds_s = ~uds_n_sync;
    assign lds_s = ~lds_n_sync;

`ifdef BERR_TIMEOUT_EN
    localparam logic [15:0] BERR_LAST = 16'(BERR_CYCLES - 1);

    logic [15:0] berr_cnt_q, berr_cnt_d;
    logic        p_berr_n_q, p_berr_n_d;

    // timeout counter: cleared on REQ entry, keeps running through DRAIN
    always_comb begin
        berr_cnt_d = berr_cnt_q;
        if (state_q == S_SETUP) begin
            berr_cnt_d = '0;
        end else if (state_q == S_REQ || state_q == S_DRAIN) begin
            berr_cnt_d = berr_cnt_q + 16'd1;
        end
    end

    // bus error output follows the BERR state
    always_comb begin
        p_berr_n_d = (state_d != S_BERR);
    end

    // timeout counter and BERR flops
    always_ff @(posedge C100 or posedge reset) begin
        if (reset) begin
            berr_cnt_q <= '0;
            p_berr_n_q <= 1'b1;
        end else begin
            berr_cnt_q <= berr_cnt_d;
            p_berr_n_q <= p_berr_n_d;
        end
    end

    assign timeout  = (berr_cnt_q == BERR_LAST);
    assign P_BERR_n = p_berr_n_q;
`else
    logic [15:0] unused_berr_cfg;
    assign unused_berr_cfg = 16'(BERR_CYCLES);
    assign timeout  = 1'b0;
    assign P_BERR_n = 1'b1;
`endif

    // next-state logic and registered bus/memory outputs
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_fc_d    = mem_fc_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        p_d_out_d   = p_d_out_q;
        wait_cnt_d  = wait_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (as_s && (uds_s || lds_s)) begin
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                mem_addr_d  = P_A;
                mem_fc_d    = P_FC;
                mem_we_d    = ~P_RW_n;
                mem_be_d    = {uds_s, lds_s};
                mem_wdata_d = P_D_in;
                mem_req_d   = 1'b1;
                state_d     = S_REQ;
            end
            S_REQ: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    // an ack racing with AS negation completes silently
                    if (!as_s) begin
                        state_d = S_IDLE;
                    end else begin
                        if (!mem_we_q) begin
                            p_d_out_d = mem_rdata;
                        end
                        if (WAIT_STATES == 0) begin
                            state_d = S_ACK;
                        end else begin
                            state_d    = S_WAIT;
                            wait_cnt_d = WAIT_LOAD;
                        end
                    end
                end else if (!as_s) begin
                    state_d = S_DRAIN;
                end else if (timeout) begin
                    mem_req_d = 1'b0;
                    state_d   = S_BERR;
                end
            end
            S_WAIT: begin
                if (!as_s) begin
                    state_d = S_IDLE;
                end else if (wait_cnt_q == 4'd0) begin
                    state_d = S_ACK;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            S_ACK, S_BERR: begin
                if (!as_s) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (mem_ack || timeout) begin
                    mem_req_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                mem_req_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase

        p_dtack_n_d = (state_d != S_ACK);
        p_d_oe_d    = (state_d == S_ACK) && !mem_we_d;
    end

    // state and output registers
    always_ff @(posedge C100 or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_fc_q    <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            p_d_out_q   <= '0;
            p_d_oe_q    <= 1'b0;
            p_dtack_n_q <= 1'b1;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_fc_q    <= mem_fc_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            p_d_out_q   <= p_d_out_d;
            p_d_oe_q    <= p_d_oe_d;
            p_dtack_n_q <= p_dtack_n_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_fc    = mem_fc_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign P_D_out   = p_d_out_q;
    assign P_D_oe    = p_d_oe_q;
    assign P_DTACK_n = p_dtack_n_q;

endmodule

// File: tb/tb_m68k_bus_slave.sv
// Scoreboard bench for m68k_bus_slave: a driver issues 68010 bus cycles and
// queues the expected memory request and DTACK response; monitors compare
// whenever the DUT raises mem_req or lowers DTACK.
module tb_m68k_bus_slave;

    localparam int S  = 2;
    localparam int W  = 2;
    localparam int BC = 16;

    logic        C100 = 1'b0;
    logic        reset = 1'b1;
    logic        P_AS_n = 1'b1;
    logic        P_RW_n = 1'b1;
    logic        P_UDS_n = 1'b1;
    logic        P_LDS_n = 1'b1;
    logic [2:0]  P_FC = 3'd0;
    logic [22:0] P_A = 23'd0;
    logic [15:0] P_D_in = 16'd0;
    logic [15:0] mem_rdata = 16'd0;
    logic        mem_ack = 1'b0;
    logic [15:0] P_D_out;
    logic        P_D_oe, P_DTACK_n, P_BERR_n, mem_req, mem_we;
    logic [22:0] mem_addr;
    logic [2:0]  mem_fc;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata;

    m68k_bus_slave #(.SYNC_STAGES(S), .WAIT_STATES(W), .BERR_CYCLES(BC)) dut (
        .C100(C100), .reset(reset), .P_AS_n(P_AS_n), .P_RW_n(P_RW_n),
        .P_UDS_n(P_UDS_n), .P_LDS_n(P_LDS_n), .P_FC(P_FC), .P_A(P_A),
        .P_D_in(P_D_in), .P_D_out(P_D_out), .P_D_oe(P_D_oe),
        .P_DTACK_n(P_DTACK_n), .P_BERR_n(P_BERR_n), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_fc(mem_fc), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    typedef struct packed {
        logic [22:0] addr;
        logic [2:0]  fc;
        logic        we;
        logic [1:0]  be;
        logic [15:0] wdata;
    } req_t;

    typedef struct packed {
        logic        is_read;
        logic [15:0] dout;
    } ack_t;

    req_t exp_req_q[$];
    ack_t exp_ack_q[$];

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_ack_cyc = 0;
    int          next_delay = 0;
    logic [15:0] next_rdata = 16'd0;
    logic [15:0] last_rd = 16'd0;
    logic [2:0]  fc_tab [5] = '{3'd1, 3'd2, 3'd5, 3'd6, 3'd7};

    always #5 C100 = ~C100;
    always @(posedge C100) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return P_DTACK_n;
            1:       return mem_req;
            default: return P_BERR_n;
        endcase
    endfunction

    task automatic wait_for(input string name, input int sel, input logic v, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge C100);
            if (sig(sel) === v) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s: level %0b not seen within %0d cycles", name, v, limit);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_dtack"}, 32'(P_DTACK_n), 32'd1);
        chk({tag, "_berr"},  32'(P_BERR_n),  32'd1);
        chk({tag, "_oe"},    32'(P_D_oe),    32'd0);
        chk({tag, "_dout"},  32'(P_D_out),   32'd0);
        chk({tag, "_req"},   32'(mem_req),   32'd0);
        chk({tag, "_we"},    32'(mem_we),    32'd0);
        chk({tag, "_addr"},  32'(mem_addr),  32'd0);
        chk({tag, "_fc"},    32'(mem_fc),    32'd0);
        chk({tag, "_be"},    32'(mem_be),    32'd0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    endtask

    // memory model: acks next_delay cycles after the request is seen
    initial begin
        forever begin
            @(negedge C100);
            if (mem_req === 1'b1) begin
                if (next_delay < 0) begin
                    for (int i = 0; i < 100 && mem_req === 1'b1; i++) @(negedge C100);
                    repeat (3) @(negedge C100);
                    mem_rdata = 16'($urandom);
                    mem_ack = 1'b1;
                    @(negedge C100);
                    mem_ack = 1'b0;
                end else begin
                    repeat (next_delay) @(negedge C100);
                    mem_rdata = next_rdata;
                    mem_ack = 1'b1;
                    last_ack_cyc = cyc;
                    @(negedge C100);
                    mem_ack = 1'b0;
                    chk("req_drop", 32'(mem_req), 32'd0);
                end
            end
        end
    end

    // request monitor
    initial begin
        logic prev;
        req_t e;
        prev = 1'b0;
        forever begin
            @(negedge C100);
            if (mem_req === 1'b1 && prev !== 1'b1) begin
                if (exp_req_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_req: mem_req raised with addr 0x%0h, none required", mem_addr);
                end else begin
                    e = exp_req_q.pop_front();
                    chk("req_addr",  32'(mem_addr),  32'(e.addr));
                    chk("req_fc",    32'(mem_fc),    32'(e.fc));
                    chk("req_we",    32'(mem_we),    32'(e.we));
                    chk("req_be",    32'(mem_be),    32'(e.be));
                    chk("req_wdata", 32'(mem_wdata), 32'(e.wdata));
                end
            end
            prev = mem_req;
        end
    end

    // DTACK monitor
    initial begin
        logic prev;
        ack_t e;
        prev = 1'b1;
        forever begin
            @(negedge C100);
            if (P_DTACK_n === 1'b0 && prev !== 1'b0) begin
                if (exp_ack_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_dtack: DTACK asserted with no cycle pending");
                end else begin
                    e = exp_ack_q.pop_front();
                    chk("dtack_lat", 32'(cyc - last_ack_cyc), 32'(1 + W));
                    chk("dtack_oe",  32'(P_D_oe),  32'(e.is_read));
                    chk("dtack_dout", 32'(P_D_out), 32'(e.dout));
                end
            end
            prev = P_DTACK_n;
        end
    end

    task automatic do_cycle(input logic [22:0] a, input logic [2:0] fc, input logic rw_n,
                            input logic [1:0] be, input logic [15:0] d, input logic [15:0] rdata,
                            input int delay, input bit abort, input bit rst_in_ack);
        req_t r;
        ack_t k;
        int   c;
        r.addr = a; r.fc = fc; r.we = ~rw_n; r.be = be; r.wdata = d;
        exp_req_q.push_back(r);
        if (!abort) begin
            if (rw_n) last_rd = rdata;
            k.is_read = rw_n;
            k.dout = last_rd;
            exp_ack_q.push_back(k);
        end
        next_delay = delay;
        next_rdata = rdata;
        @(negedge C100);
        P_A = a; P_FC = fc; P_RW_n = rw_n; P_D_in = d;
        P_AS_n = 1'b0; P_UDS_n = ~be[1]; P_LDS_n = ~be[0];
        if (abort) begin
            wait_for("abort_req", 1, 1'b1, 40);
            P_AS_n = 1'b1; P_UDS_n = 1'b1; P_LDS_n = 1'b1;
            wait_for("abort_drain", 1, 1'b0, 60);
            repeat (S + 3) @(negedge C100);
            chk("abort_no_dtack", 32'(P_DTACK_n), 32'd1);
            return;
        end
        wait_for("dtack_assert", 0, 1'b0, 60);
        if (rst_in_ack) begin
            #2 reset = 1'b1;
            #1 check_reset("rst_ack");
            P_AS_n = 1'b1; P_UDS_n = 1'b1; P_LDS_n = 1'b1;
            last_rd = 16'd0;
            repeat (2) @(negedge C100);
            reset = 1'b0;
            return;
        end
        repeat ($urandom_range(0, 2)) @(negedge C100);
        c = cyc;
        P_AS_n = 1'b1; P_UDS_n = 1'b1; P_LDS_n = 1'b1;
        wait_for("dtack_release", 0, 1'b1, 40);
        chk("release_lat", 32'(cyc - c), 32'(S + 1));
        chk("release_oe", 32'(P_D_oe), 32'd0);
    endtask

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "watchdog");
    end

    // stimulus
    initial begin
        logic [1:0] be;
        logic       rw;
        bit         ab;
        repeat (3) @(negedge C100);
        check_reset("rst0");
        reset = 1'b0;
        repeat (3) @(negedge C100);

        do_cycle(23'h000800, 3'd5, 1'b1, 2'b11, 16'h0000, 16'hBEEF, 3, 1'b0, 1'b0);
        repeat (2) @(negedge C100);
        do_cycle(23'h000101, 3'd1, 1'b0, 2'b10, 16'h5A00, 16'h1234, 2, 1'b0, 1'b0);
        repeat (2) @(negedge C100);
        do_cycle(23'h000102, 3'd5, 1'b1, 2'b01, 16'h0000, 16'hC3A5, 0, 1'b0, 1'b0);
        repeat (2) @(negedge C100);
        do_cycle(23'h003000, 3'd6, 1'b1, 2'b11, 16'h0000, 16'h7777, 10, 1'b1, 1'b0);
        repeat (2) @(negedge C100);
        do_cycle(23'h003001, 3'd6, 1'b1, 2'b11, 16'h0000, 16'h4242, 1, 1'b0, 1'b0);
        repeat (2) @(negedge C100);

`ifdef BERR_TIMEOUT_EN
        begin
            req_t r;
            int   rc;
            r.addr = 23'h7FFFFF; r.fc = 3'd2; r.we = 1'b0; r.be = 2'b11; r.wdata = 16'h0;
            exp_req_q.push_back(r);
            next_delay = -1;
            @(negedge C100);
            P_A = 23'h7FFFFF; P_FC = 3'd2; P_RW_n = 1'b1; P_D_in = 16'h0;
            P_AS_n = 1'b0; P_UDS_n = 1'b0; P_LDS_n = 1'b0;
            wait_for("berr_req", 1, 1'b1, 40);
            rc = cyc;
            wait_for("berr_assert", 2, 1'b0, BC + 20);
            chk("berr_lat", 32'(cyc - rc), 32'(BC));
            chk("berr_req_low", 32'(mem_req), 32'd0);
            P_AS_n = 1'b1; P_UDS_n = 1'b1; P_LDS_n = 1'b1;
            wait_for("berr_release", 2, 1'b1, 40);
            repeat (8) @(negedge C100);
            chk("berr_late_ack", 32'(P_DTACK_n), 32'd1);
        end
`endif

        do_cycle(23'h000400, 3'd5, 1'b1, 2'b11, 16'h0000, 16'hA5A5, 2, 1'b0, 1'b1);
        repeat (2) @(negedge C100);
        do_cycle(23'h000401, 3'd5, 1'b1, 2'b11, 16'h0000, 16'h0F0F, 1, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(1, 3)) @(negedge C100);
            rw = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       be = 2'b11;
                1:       be = 2'b10;
                default: be = 2'b01;
            endcase
            ab = ($urandom_range(0, 5) == 0);
            do_cycle(23'($urandom), fc_tab[$urandom_range(0, 4)], rw, be, 16'($urandom),
                     16'($urandom), ab ? 10 + $urandom_range(0, 4) : $urandom_range(0, 6),
                     ab, 1'b0);
        end

        repeat (10) @(negedge C100);
        chk("req_queue_empty", 32'(exp_req_q.size()), 32'd0);
        chk("ack_queue_empty", 32'(exp_ack_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
